bcd_convert: RTL and testbench

Sequential binary-to-BCD converter between the signed 8×8 multiplier and the 7-segment display driver. Accepts the 16-bit two's-complement product on a start pulse and separates it into a sign flag and magnitude. Converts the magnitude to five packed BCD digits by shift-and-add-3 (double dabble), one bit per clock. Reports the count of significant digits so the display can scroll and blank leading zeros.

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_adjust.sv | 9 +
 rtl/bcd_convert.sv | 88 ++++++++
 tb/tb_bcd_convert.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and state encoding for the binary-to-BCD converter
package bcd_pkg;

  localparam int BCD_WIDTH  = 16;
  localparam int BCD_DIGITS = 5;
  localparam int BCD_CNT_W  = $clog2(BCD_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_FIN
  } state_t;

endpackage

// File: rtl/bcd_adjust.sv
// rtl/bcd_adjust.sv - double-dabble digit correction: add 3 to any digit of 5 or more
module bcd_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bcd_convert.sv
// rtl/bcd_convert.sv - sequential signed binary to packed BCD converter, one bit per clock
module bcd_convert
  import bcd_pkg::*;
#(
  parameter int WIDTH  = BCD_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic                sign,
  output logic [4*DIGITS-1:0] bcd,
  output logic [2:0]          ndigits
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [WIDTH-1:0]    sreg;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] adj;
  logic [2:0]          nd_next;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_adjust u_adj (
        .digit    (scratch[4*g +: 4]),
        .adjusted (adj[4*g +: 4])
      );
    end
  endgenerate

  // Highest nonzero digit wins; an all-zero result still reports one digit.
  always_comb begin
    nd_next = 3'd1;
    for (int i = 1; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] != 4'd0) nd_next = 3'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sreg    <= '0;
      scratch <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sign    <= 1'b0;
      bcd     <= '0;
      ndigits <= 3'd1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sign    <= bin[WIDTH-1];
            // Negating full scale wraps to itself, which is the correct unsigned magnitude.
            sreg    <= bin[WIDTH-1] ? (~bin + WIDTH'(1)) : bin;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= ST_CONV;
          end
        end
        ST_CONV: begin
          {scratch, sreg} <= {adj, sreg} << 1;
          cnt             <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIN;
        end
        ST_FIN: begin
          bcd     <= scratch;
          ndigits <= nd_next;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert.sv
// tb/tb_bcd_convert.sv - scoreboard bench for bcd_convert with a decimal-arithmetic reference
module tb_bcd_convert;

  localparam int W   = 16;
  localparam int D   = 5;
  localparam int LAT = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  bin;
  logic          busy;
  logic          done;
  logic          sign;
  logic [4*D-1:0] bcd;
  logic [2:0]    ndigits;

  bcd_convert #(.WIDTH(W), .DIGITS(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .sign    (sign),
    .bcd     (bcd),
    .ndigits (ndigits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           sign;
    logic [4*D-1:0] bcd;
    logic [2:0]     nd;
    int             issue;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t last_res;
  int   cyc       = 0;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   done_cyc  = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] v);
    exp_t e;
    int   val;
    int   mag;
    int   tmp;
    val   = int'($signed(v));
    e.sign = (val < 0);
    mag   = (val < 0) ? -val : val;
    tmp   = mag;
    e.bcd = '0;
    for (int i = 0; i < D; i++) begin
      e.bcd[4*i +: 4] = 4'(tmp % 10);
      tmp = tmp / 10;
    end
    e.nd = 3'd1;
    tmp  = mag;
    while (tmp >= 10) begin
      e.nd = e.nd + 3'd1;
      tmp  = tmp / 10;
    end
    e.issue = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total_cnt++;
    if (act === exp_v) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_done) chk("done_one_cycle", {31'd0, done}, 32'd0);
      if (done) begin
        done_cyc <= cyc;
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("sign",    {31'd0, sign}, {31'd0, mon_e.sign});
          chk("bcd",     {12'd0, bcd}, {12'd0, mon_e.bcd});
          chk("ndigits", {29'd0, ndigits}, {29'd0, mon_e.nd});
          chk("busy_at_done", {31'd0, busy}, 32'd0);
          chk("latency", cyc - mon_e.issue, LAT);
          last_res = mon_e;
        end
      end
    end
    prev_done <= done;
  end

  task automatic issue(input logic [W-1:0] v);
    exp_t e;
    e       = model(v);
    start   = 1'b1;
    bin     = v;
    e.issue = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = W'($urandom);
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
  endtask

  logic [W-1:0]   dir_v   [6] = '{16'h0000, 16'hC080, 16'h4000, 16'hFFFF, 16'h8000, 16'h0064};
  logic [4*D-1:0] dir_bcd [6] = '{20'h00000, 20'h16256, 20'h16384, 20'h00001, 20'h32768, 20'h00100};
  logic           dir_sgn [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [2:0]     dir_nd  [6] = '{3'd1, 3'd5, 3'd5, 3'd1, 3'd5, 3'd3};

  initial begin
    bit seen;
    int first_done;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy",    {31'd0, busy}, 32'd0);
    chk("rst_done",    {31'd0, done}, 32'd0);
    chk("rst_bcd",     {12'd0, bcd}, 32'd0);
    chk("rst_ndigits", {29'd0, ndigits}, 32'd1);
    chk("rst_sign",    {31'd0, sign}, 32'd0);

    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      issue(dir_v[k]);
      wait_done(seen);
      chk("dir_bcd",     {12'd0, bcd}, {12'd0, dir_bcd[k]});
      chk("dir_sign",    {31'd0, sign}, {31'd0, dir_sgn[k]});
      chk("dir_ndigits", {29'd0, ndigits}, {29'd0, dir_nd[k]});
    end

    @(posedge clk);
    #1;
    issue(16'h0007);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_in_conv", {31'd0, busy}, 32'd1);
    chk("hold_bcd",     {12'd0, bcd}, {12'd0, last_res.bcd});
    chk("hold_ndigits", {29'd0, ndigits}, {29'd0, last_res.nd});
    start = 1'b1;
    bin   = 16'h1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(seen);
    chk("ignored_start_bcd", {12'd0, bcd}, 32'h00007);
    repeat (25) @(posedge clk);
    #1;
    chk("idle_after_ignore", {31'd0, busy}, 32'd0);

    issue(16'h0999);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy",    {31'd0, busy}, 32'd0);
    chk("abort_bcd",     {12'd0, bcd}, 32'd0);
    chk("abort_ndigits", {29'd0, ndigits}, 32'd1);
    chk("abort_sign",    {31'd0, sign}, 32'd0);
    repeat (25) @(posedge clk);
    #1;
    issue(16'h3039);
    wait_done(seen);
    chk("after_abort_bcd", {12'd0, bcd}, 32'h12345);

    @(posedge clk);
    #1;
    issue(16'hFB2E);
    wait_done(seen);
    first_done = cyc;
    issue(16'h0401);
    wait_done(seen);
    chk("back_to_back_gap", cyc - first_done, LAT);
    chk("back_to_back_bcd", {12'd0, bcd}, 32'h01025);

    for (int i = 0; i < 40; i++) begin
      if (i == 0 || $urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      issue(W'($urandom));
      wait_done(seen);
    end

    repeat (30) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
